uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one UART transmit controller among NUM_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX controller among NUM_REQ byte sources.
// A grant is held for a whole message and paced on the controller's Full flag.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic                   Clock_50,
    input  logic                   Resetn,
    input  logic                   Enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_Enable,
    output logic                   tx_Load_data,
    output logic [7:0]             tx_w_data,
    input  logic                   tx_Full,
    output logic [2:0]             grant_id,
    output logic                   locked,
    output logic                   lock_abort
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DRAIN,
        HOLD
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   hold_cnt;

    // Requester vectors padded to 8 entries so a 3-bit index always fits exactly
    logic [7:0]         valid_pad;
    logic [7:0]         last_pad;
    logic [63:0]        data_pad;

    logic [3:0]         cand;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               do_issue;

    assign valid_pad = 8'(req_valid);
    assign last_pad  = 8'(req_last);
    assign data_pad  = 64'(req_data);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 4'(rr_ptr) + 4'(i);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && valid_pad[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // While a message is locked only the current owner may load
    always_comb begin
        sel_idx  = (state == HOLD) ? grant_id : win_idx;
        sel_data = data_pad[{sel_idx, 3'b000} +: 8];
        sel_last = last_pad[sel_idx];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_onehot[i] = (sel_idx == IDX_W'(i));
        end
        do_issue = ((state == IDLE) && Enable && !tx_Full && win_found) ||
                   ((state == HOLD) && Enable && valid_pad[grant_id]);
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            req_ready    <= '0;
            tx_Enable    <= 1'b0;
            tx_Load_data <= 1'b0;
            tx_w_data    <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            lock_abort   <= 1'b0;
        end else begin
            tx_Enable    <= Enable;
            tx_Load_data <= 1'b0;
            req_ready    <= '0;
            lock_abort   <= 1'b0;

            if (do_issue) begin
                grant_id     <= sel_idx;
                tx_Load_data <= 1'b1;
                tx_w_data    <= sel_data;
                req_ready    <= sel_onehot;
                locked       <= !sel_last;
                if (sel_last) begin
                    rr_ptr <= next_idx(sel_idx);
                end
            end

            case (state)
                IDLE: begin
                    if (do_issue) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_Full) begin
                        state <= WAIT_DRAIN;
                    end
                end
                WAIT_DRAIN: begin
                    if (!tx_Full) begin
                        state <= locked ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (do_issue) begin
                        hold_cnt <= '0;
                        state    <= LOAD;
                    end else if (hold_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        hold_cnt   <= '0;
                        lock_abort <= 1'b1;
                        locked     <= 1'b0;
                        rr_ptr     <= next_idx(grant_id);
                        state      <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked against
// a message-queue model of round-robin arbitration with per-message locking.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned LOCK_TIMEOUT = 20;

    logic                   Clock_50 = 1'b0;
    logic                   Resetn   = 1'b0;
    logic                   Enable   = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [8*NUM_REQ-1:0]   req_data  = '0;
    logic [NUM_REQ-1:0]     req_last  = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_Enable;
    logic                   tx_Load_data;
    logic [7:0]             tx_w_data;
    logic                   tx_Full = 1'b0;
    logic [2:0]             grant_id;
    logic                   locked;
    logic                   lock_abort;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .Clock_50     (Clock_50),
        .Resetn       (Resetn),
        .Enable       (Enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_Enable    (tx_Enable),
        .tx_Load_data (tx_Load_data),
        .tx_w_data    (tx_w_data),
        .tx_Full      (tx_Full),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_abort   (lock_abort)
    );

    always #5 Clock_50 = ~Clock_50;

    // Model state: pending bytes {last,data} per requester, rotation pointer, lock owner
    logic [8:0] mq [NUM_REQ][$];
    int rr    = 0;
    int owner = -1;
    int vectors     = 0;
    int miscompares = 0;
    int loads_seen  = 0;
    int grant_log[$];

    // TX controller model
    bit busy = 0;
    int full_wait = 0;
    int full_hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner();
        if (owner >= 0) return owner;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            int idx;
            idx = (rr + i) % int'(NUM_REQ);
            if (mq[idx].size() != 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (mq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_reqs();
        logic [8:0] b;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (mq[i].size() != 0) begin
                b = mq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = b[7:0];
                req_last[i]        = b[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        mq[r].push_back({last, d});
    endtask

    // One clock: sample after the edge, check against the model, advance TX model, redrive
    task automatic tick();
        logic       en_at_edge;
        bit         busy_at_edge;
        bit         just_loaded;
        int         w;
        logic [8:0] b;
        en_at_edge   = Enable;
        busy_at_edge = busy;
        just_loaded  = 0;
        @(posedge Clock_50);
        #1;
        chk("tx_enable_delay", 32'(tx_Enable), 32'(en_at_edge));
        if (tx_Load_data) begin
            loads_seen++;
            w = exp_winner();
            chk("load_allowed", {30'd0, en_at_edge, busy_at_edge}, 32'h2);
            chk("load_has_winner", 32'(w >= 0), 32'd1);
            if (w >= 0) begin
                b = mq[w][0];
                chk("grant_id", 32'(grant_id), 32'(w));
                chk("w_data", 32'(tx_w_data), 32'(b[7:0]));
                chk("req_ready", 32'(req_ready), 32'(1) << w);
                void'(mq[w].pop_front());
                grant_log.push_back(w);
                if (b[8]) begin
                    owner = -1;
                    rr    = (w + 1) % int'(NUM_REQ);
                end else begin
                    owner = w;
                end
            end
            busy        = 1;
            full_wait   = $urandom_range(0, 2);
            just_loaded = 1;
        end else begin
            chk("req_ready_quiet", 32'(req_ready), 32'd0);
        end
        if (lock_abort) begin
            chk("abort_expected", 32'(owner >= 0), 32'd1);
            if (owner >= 0) rr = (owner + 1) % int'(NUM_REQ);
            owner = -1;
        end
        chk("locked", 32'(locked), 32'(owner >= 0));
        if (busy && !just_loaded) begin
            if (!tx_Full) begin
                if (full_wait > 0) full_wait--;
                else begin
                    tx_Full   = 1'b1;
                    full_hold = $urandom_range(1, 4);
                end
            end else if (full_hold > 1) begin
                full_hold--;
            end else begin
                tx_Full = 1'b0;
                busy    = 0;
            end
        end
        drive_reqs();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_tx_enable"}, 32'(tx_Enable), 32'd0);
        chk({tag, "_load"}, 32'(tx_Load_data), 32'd0);
        chk({tag, "_w_data"}, 32'(tx_w_data), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_abort"}, 32'(lock_abort), 32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NUM_REQ); i++) mq[i].delete();
        rr = 0;
        owner = -1;
        busy = 0;
        tx_Full = 1'b0;
        grant_log.delete();
        drive_reqs();
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        clear_model();
        repeat (2) @(posedge Clock_50);
        #1;
        chk_zero("reset");
        Resetn = 1'b1;
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((any_pending() || busy || owner >= 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_budget", 32'(n < budget), 32'd1);
        repeat (3) tick();
    endtask

    task automatic chk_log(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, 32'(grant_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++) begin
            chk(tag, 32'(grant_log[k]), 32'(exp_q[k]));
        end
        grant_log.delete();
    endtask

    initial begin
        int n;
        int loads_before;

        // 1: single-byte message from req0, one-cycle latency, no lock
        Enable = 1'b1;
        do_reset();
        push_byte(0, 8'h41, 1'b1);
        drive_reqs();
        tick();
        chk("t1_latency", 32'(tx_Load_data), 32'd1);
        run_drain(100);
        chk_log("t1_order", '{0});

        // 2: all four requesting single bytes, req0 twice
        do_reset();
        push_byte(0, 8'h10, 1'b1);
        push_byte(1, 8'h11, 1'b1);
        push_byte(2, 8'h12, 1'b1);
        push_byte(3, 8'h13, 1'b1);
        push_byte(0, 8'h20, 1'b1);
        drive_reqs();
        run_drain(200);
        chk_log("t2_order", '{0, 1, 2, 3, 0});

        // 3: req2 three-byte message holds the grant against competitors
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b0);
        push_byte(2, 8'h43, 1'b1);
        drive_reqs();
        tick();
        chk("t3_first_load", 32'(tx_Load_data), 32'd1);
        push_byte(0, 8'h30, 1'b1);
        push_byte(1, 8'h31, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        drive_reqs();
        run_drain(300);
        chk_log("t3_order", '{2, 2, 2, 3, 0, 1});

        // 4: req1 locks then stalls until timeout; others wait
        push_byte(1, 8'h51, 1'b0);
        drive_reqs();
        tick();
        chk("t4_lock_load", 32'(locked), 32'd1);
        push_byte(2, 8'h52, 1'b1);
        push_byte(0, 8'h50, 1'b1);
        drive_reqs();
        n = 0;
        do begin
            tick();
            n++;
        end while (!lock_abort && n < int'(LOCK_TIMEOUT) + 40);
        chk("t4_abort_seen", 32'(lock_abort), 32'd1);
        chk("t4_abort_window", 32'(n >= int'(LOCK_TIMEOUT) && n <= int'(LOCK_TIMEOUT) + 10), 32'd1);
        tick();
        chk("t4_abort_pulse", 32'(lock_abort), 32'd0);
        run_drain(200);
        chk_log("t4_order", '{1, 2, 0});

        // 5: Enable drops while a byte drains; next load waits for Enable
        push_byte(0, 8'h60, 1'b1);
        drive_reqs();
        tick();
        n = 0;
        while (!tx_Full && n < 20) begin
            tick();
            n++;
        end
        chk("t5_full_seen", 32'(tx_Full), 32'd1);
        Enable = 1'b0;
        push_byte(1, 8'h61, 1'b1);
        drive_reqs();
        loads_before = loads_seen;
        repeat (12) tick();
        chk("t5_no_load", 32'(loads_seen - loads_before), 32'd0);
        chk("t5_drained", 32'(busy), 32'd0);
        Enable = 1'b1;
        tick();
        chk("t5_resume", 32'(tx_Load_data), 32'd1);
        run_drain(200);
        chk_log("t5_order", '{0, 1});

        // 6: asynchronous reset while waiting for the controller to accept
        push_byte(2, 8'h70, 1'b1);
        drive_reqs();
        tick();
        chk("t6_load", 32'(tx_Load_data), 32'd1);
        full_wait = 10;
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        chk_zero("t6_async");
        clear_model();
        @(posedge Clock_50);
        #1;
        Resetn = 1'b1;
        push_byte(3, 8'h73, 1'b1);
        push_byte(0, 8'h80, 1'b1);
        drive_reqs();
        run_drain(200);
        chk_log("t6_order", '{0, 3});

        // Random traffic: variable-length messages, occasional Enable drops
        do_reset();
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) begin
                int r;
                int len;
                r = $urandom_range(0, NUM_REQ - 1);
                if (mq[r].size() < 4) begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) begin
                        push_byte(r, 8'($urandom), k == len - 1);
                    end
                    drive_reqs();
                end
            end
            Enable = ($urandom_range(0, 9) != 0);
            tick();
        end
        Enable = 1'b1;
        run_drain(2000);
        chk("rand_activity", 32'(loads_seen > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
